// File: rtl/aes_pkg.sv
// Shared AES datapath types: state width, byte width, byte-ordered state and the
// SubBytes sequencer states.
package aes_pkg;

  localparam int unsigned AES_STATE_W = 128;
  localparam int unsigned AES_BYTE_W  = 8;

  // Byte 0 occupies the most significant bits.
  typedef logic [0:15][AES_BYTE_W-1:0] aes_state_t;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} sub_bytes_state_t;

endpackage

// File: rtl/sbox.sv
// Combinational AES forward S-box lookup; the address is the full byte value.
module sbox (
  input  logic [7:0] addr,
  output logic [7:0] data
);

  localparam logic [0:255][7:0] TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  assign data = TABLE[addr];

endmodule

// File: rtl/sub_bytes_serial.sv
// Byte-serial AES SubBytes: LANES sbox lookups per cycle over a 128-bit buffer.
// Define SUB_BYTES_REG_LOOKUP_EN to register each lane's lookup (adds a DRAIN state).
module sub_bytes_serial
  import aes_pkg::*;
#(
  parameter int unsigned BYTES = 16,
  parameter int unsigned LANES = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [AES_STATE_W-1:0] in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [AES_STATE_W-1:0] out_data,
  output logic                   busy
);

  localparam int unsigned IW = $clog2(BYTES) + 1;
  localparam int unsigned OW = IW - 1;
  localparam logic [IW-1:0] STEP = IW'(LANES);
  localparam logic [IW-1:0] LAST = IW'(BYTES - LANES);

  sub_bytes_state_t      state;
  logic [IW-1:0]         idx;
  aes_state_t            buf_q;
  logic [OW-1:0]         off;
  logic [AES_BYTE_W-1:0] sb_in  [LANES];
  logic [AES_BYTE_W-1:0] sb_out [LANES];

  logic                  wr_en;
  logic [OW-1:0]         wr_off;
  logic [AES_BYTE_W-1:0] wr_data [LANES];

  // idx reaches BYTES after the last group; the low bits wrap back to a legal byte.
  assign off = idx[OW-1:0];

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    localparam logic [OW-1:0] LANE_OFF = OW'(g);
    assign sb_in[g] = buf_q[off + LANE_OFF];
    sbox u_sbox (
      .addr (sb_in[g]),
      .data (sb_out[g])
    );
  end

`ifdef SUB_BYTES_REG_LOOKUP_EN
  logic [AES_BYTE_W-1:0] lk_q [LANES];
  logic [OW-1:0]         lk_off_q;
  logic                  lk_vld_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int l = 0; l < LANES; l++) lk_q[l] <= '0;
      lk_off_q <= '0;
      lk_vld_q <= 1'b0;
    end else begin
      for (int l = 0; l < LANES; l++) lk_q[l] <= sb_out[l];
      lk_off_q <= off;
      lk_vld_q <= (state == RUN);
    end
  end

  assign wr_en   = lk_vld_q;
  assign wr_off  = lk_off_q;
  assign wr_data = lk_q;
`else
  assign wr_en   = (state == RUN);
  assign wr_off  = off;
  assign wr_data = sb_out;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      idx   <= '0;
      buf_q <= '0;
    end else begin
      if (state == IDLE && in_valid) begin
        buf_q <= in_data;
      end else if (wr_en) begin
        for (int l = 0; l < LANES; l++) buf_q[wr_off + OW'(l)] <= wr_data[l];
      end

      case (state)
        IDLE: begin
          if (in_valid) begin
            state <= RUN;
            idx   <= '0;
          end
        end
        RUN: begin
          idx <= idx + STEP;
          if (idx == LAST) begin
`ifdef SUB_BYTES_REG_LOOKUP_EN
            state <= DRAIN;
`else
            state <= DONE;
`endif
          end
        end
        DRAIN: state <= DONE;
        DONE:  if (out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign out_data  = out_valid ? buf_q : '0;
  assign busy      = (state == RUN) || (state == DRAIN);

endmodule

// File: tb/tb_sub_bytes_serial.sv
// Directed bench for sub_bytes_serial; follows SUB_BYTES_REG_LOOKUP_EN and LANES.
module tb_sub_bytes_serial;

  parameter int unsigned LANES = 1;

`ifdef SUB_BYTES_REG_LOOKUP_EN
  localparam int LAT = 16 / LANES + 1;
`else
  localparam int LAT = 16 / LANES;
`endif
  localparam int LIMIT = 60;

  localparam logic [127:0] VEC  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] RES  = 128'h638293c31bfc33f5c4eeacea4bc12816;
  localparam logic [127:0] ZRES = {16{8'h63}};
  localparam logic [127:0] ONES = {16{8'hff}};
  localparam logic [127:0] FRES = {16{8'h16}};

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;
  logic         busy;

  int n_cmp;
  int n_bad;

  sub_bytes_serial #(
    .BYTES (16),
    .LANES (LANES)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Called at a negedge; returns at the negedge right after the accept edge.
  task automatic send(input logic [127:0] d);
    in_valid = 1'b1;
    in_data  = d;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Counts cycles after the accept edge until out_valid, and busy samples on the way.
  task automatic wait_out(output int cyc, output int busy_cnt);
    cyc = 0;
    busy_cnt = 0;
    while (!out_valid && cyc < LIMIT) begin
      if (busy) busy_cnt++;
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    n_cmp++; if (out_data !== '0) begin n_bad++; $display("FAIL reset_out_data got %h want 0", out_data); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", busy); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic;
    int cyc, bc;
    out_ready = 1'b1;
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL basic_in_ready got %b want 1", in_ready); end
    send(VEC);
    wait_out(cyc, bc);
    n_cmp++; if (cyc !== LAT) begin n_bad++; $display("FAIL basic_latency got %0d want %0d", cyc, LAT); end
    n_cmp++; if (out_data !== RES) begin n_bad++; $display("FAIL basic_data got %h want %h", out_data, RES); end
    @(negedge clk);
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL basic_post_valid got %b want 0", out_valid); end
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL basic_post_ready got %b want 1", in_ready); end
  endtask

  task automatic test_zero;
    int cyc, bc;
    send('0);
    wait_out(cyc, bc);
    n_cmp++; if (out_data !== ZRES) begin n_bad++; $display("FAIL zero_data got %h want %h", out_data, ZRES); end
    n_cmp++; if (bc !== LAT) begin n_bad++; $display("FAIL zero_busy_cycles got %0d want %0d", bc, LAT); end
    @(negedge clk);
  endtask

  task automatic test_backpressure;
    int cyc, bc;
    out_ready = 1'b0;
    send(VEC);
    wait_out(cyc, bc);
    n_cmp++; if (cyc !== LAT) begin n_bad++; $display("FAIL bp_latency got %0d want %0d", cyc, LAT); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL bp_valid[%0d] got %b want 1", i, out_valid); end
      n_cmp++; if (out_data !== RES) begin n_bad++; $display("FAIL bp_data[%0d] got %h want %h", i, out_data, RES); end
      n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_in_ready[%0d] got %b want 0", i, in_ready); end
    end
    out_ready = 1'b1;
    @(negedge clk);
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL bp_release_valid got %b want 0", out_valid); end
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL bp_release_ready got %b want 1", in_ready); end
  endtask

  task automatic test_busy_ignore;
    int cyc, bc;
    out_ready = 1'b1;
    send(VEC);
    repeat (2) @(negedge clk);
    // Keep offering an all-ones state through RUN and DONE.
    in_valid = 1'b1;
    in_data  = ONES;
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL ign_in_ready got %b want 0", in_ready); end
    wait_out(cyc, bc);
    n_cmp++; if (out_data !== RES) begin n_bad++; $display("FAIL ign_data got %h want %h", out_data, RES); end
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL ign_idle_busy got %b want 0", busy); end
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL ign_idle_ready got %b want 1", in_ready); end
    @(negedge clk);
    in_valid = 1'b0;
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL ign_second_busy got %b want 1", busy); end
    wait_out(cyc, bc);
    n_cmp++; if (out_data !== FRES) begin n_bad++; $display("FAIL ign_second_data got %h want %h", out_data, FRES); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    int cyc, bc;
    out_ready = 1'b1;
    send(VEC);
    repeat (7) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rstmid_busy got %b want 0", busy); end
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL rstmid_in_ready got %b want 1", in_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rstmid_out_valid got %b want 0", out_valid); end
    n_cmp++; if (out_data !== '0) begin n_bad++; $display("FAIL rstmid_out_data got %h want 0", out_data); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rstmid_no_output got %b want 0", out_valid); end
    send(VEC);
    wait_out(cyc, bc);
    n_cmp++; if (cyc !== LAT) begin n_bad++; $display("FAIL rstmid_latency got %0d want %0d", cyc, LAT); end
    n_cmp++; if (out_data !== RES) begin n_bad++; $display("FAIL rstmid_data got %h want %h", out_data, RES); end
    @(negedge clk);
  endtask

  initial begin
    n_cmp     = 0;
    n_bad     = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    @(negedge clk);
    test_reset();
    test_basic();
    test_zero();
    test_backpressure();
    test_busy_ignore();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
